// File: rtl/branch_redirect_ctrl.sv
// Fetch PC owner: sequences branch/jump redirects, flush windows, stalls and halts.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            ex_valid_i,
    input  logic            branch_con_i,
    input  logic            ex_jump_i,
    input  logic            ex_halt_i,
    input  logic [XLEN-1:0] ex_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            if_id_flush_o,
    output logic            id_ex_flush_o,
    output logic            redirect_o,
    output logic            misaligned_o,
    output logic            halted_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     taken_cnt_o,
    output logic [31:0]     jump_cnt_o,
    output logic [31:0]     flush_cycles_cnt_o
`endif
);

    typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

    localparam logic [2:0] CntInit = 3'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            redirect_q, redirect_d;
    logic            mis_q, mis_d;
    logic            halted_q, halted_d;
    logic            live, req, accept;
    logic [XLEN-1:0] tgt, pc_inc;

    // The instruction in EX right after a redirect is already squashed (matters for FLUSH_CYCLES=1).
    assign live   = ex_valid_i & ~redirect_q;
    assign req    = live & (branch_con_i | ex_jump_i);
    assign tgt    = {ex_target_i[XLEN-1:1], 1'b0};
    assign pc_inc = pc_q + XLEN'(4);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        redirect_d = 1'b0;
        mis_d      = mis_q;
        halted_d   = halted_q;
        accept     = 1'b0;
        unique case (state_q)
            StRun: begin
                if (live && ex_halt_i) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else if (req && ex_target_i[1]) begin
                    state_d  = StHalt;
                    mis_d    = 1'b1;
                    halted_d = 1'b1;
                end else if (req) begin
                    accept     = 1'b1;
                    pc_d       = tgt;
                    redirect_d = 1'b1;
                    flush_d    = 1'b1;
                    cnt_d      = CntInit;
                    state_d    = (FLUSH_CYCLES > 1) ? StFlush : StRun;
                end else if (!stall_i) begin
                    pc_d = pc_inc;
                end
            end
            StFlush: begin
                if (!stall_i) begin
                    pc_d = pc_inc;
                end
                if (cnt_q == 3'd0) begin
                    state_d = StRun;
                end else begin
                    flush_d = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StRun;
            cnt_q      <= 3'd0;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            mis_q      <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            mis_q      <= mis_d;
            halted_q   <= halted_d;
        end
    end

    assign pc_o          = pc_q;
    assign if_id_flush_o = flush_q;
    assign id_ex_flush_o = flush_q;
    assign redirect_o    = redirect_q;
    assign misaligned_o  = mis_q;
    assign halted_o      = halted_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_q, jump_q, fcyc_q;
    logic        run_ok;

    assign run_ok = (state_q != StHalt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taken_q <= '0;
            jump_q  <= '0;
            fcyc_q  <= '0;
        end else if (run_ok) begin
            // Both branch_con and ex_jump set counts as a jump only.
            if (accept && branch_con_i && !ex_jump_i && taken_q != '1) begin
                taken_q <= taken_q + 32'd1;
            end
            if (accept && ex_jump_i && jump_q != '1) begin
                jump_q <= jump_q + 32'd1;
            end
            if (flush_q && fcyc_q != '1) begin
                fcyc_q <= fcyc_q + 32'd1;
            end
        end
    end

    assign taken_cnt_o        = taken_q;
    assign jump_cnt_o         = jump_q;
    assign flush_cycles_cnt_o = fcyc_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: expected outputs are queued when inputs are driven
// and compared one cycle later.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, ex_valid, branch_con, ex_jump, ex_halt;
    logic [31:0] ex_target;
    logic [31:0] pc;
    logic        if_id_flush, id_ex_flush, redirect, misaligned, halted;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt, jump_cnt, flush_cycles_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb_q[$];

    branch_redirect_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .ex_valid_i    (ex_valid),
        .branch_con_i  (branch_con),
        .ex_jump_i     (ex_jump),
        .ex_halt_i     (ex_halt),
        .ex_target_i   (ex_target),
        .pc_o          (pc),
        .if_id_flush_o (if_id_flush),
        .id_ex_flush_o (id_ex_flush),
        .redirect_o    (redirect),
        .misaligned_o  (misaligned),
        .halted_o      (halted)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt_o        (taken_cnt),
        .jump_cnt_o         (jump_cnt),
        .flush_cycles_cnt_o (flush_cycles_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // flags = {if_id_flush, id_ex_flush, redirect, misaligned, halted}
    task automatic cyc(input logic r, st, v, bc, j, h, input logic [31:0] tgt,
                       input string tag, input logic [31:0] epc, input logic [4:0] eflags);
        exp_t e;
        rst        = r;
        stall      = st;
        ex_valid   = v;
        branch_con = bc;
        ex_jump    = j;
        ex_halt    = h;
        ex_target  = tgt;
        sb_q.push_back('{tag: tag, pc: epc, flags: eflags});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val({e.tag, ".pc"}, pc, e.pc);
        check_val({e.tag, ".flags"},
                  {27'd0, if_id_flush, id_ex_flush, redirect, misaligned, halted},
                  {27'd0, e.flags});
    endtask

    task automatic idle(input string tag, input logic [31:0] epc, input logic [4:0] eflags);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, tag, epc, eflags);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; branch_con = 1'b0;
        ex_jump = 1'b0; ex_halt = 1'b0; ex_target = '0;
        @(negedge clk);

        cyc(1, 0, 0, 0, 0, 0, 32'h0, "reset", 32'h0, 5'b00000);
        for (int i = 1; i <= 3; i++) idle("free", 32'(4 * i), 5'b00000);
        idle("free4", 32'h10, 5'b00000);

        cyc(0, 1, 0, 0, 0, 0, 32'h0, "stall1", 32'h10, 5'b00000);
        cyc(0, 1, 0, 0, 0, 0, 32'h0, "stall2", 32'h10, 5'b00000);
        idle("resume", 32'h14, 5'b00000);
        for (int i = 1; i <= 11; i++) idle("run", 32'h14 + 32'(4 * i), 5'b00000);
        cyc(1, 0, 0, 0, 0, 0, 32'h0, "rst_mid", 32'h0, 5'b00000);

        // Branch/halt without ex_valid must be ignored
        cyc(0, 0, 0, 1, 0, 0, 32'h500, "noreq", 32'h4, 5'b00000);
        cyc(0, 0, 0, 0, 0, 1, 32'h0, "nohalt", 32'h8, 5'b00000);

        // Taken branch beats stall, second req inside the window is ignored
        cyc(0, 1, 1, 1, 0, 0, 32'h100, "br_n1", 32'h100, 5'b11100);
        cyc(0, 0, 1, 1, 0, 0, 32'h200, "br_n2", 32'h104, 5'b11000);
        idle("br_n3", 32'h108, 5'b00000);

        cyc(0, 0, 1, 0, 1, 0, 32'h301, "jmp_n1", 32'h300, 5'b11100);
        idle("jmp_n2", 32'h304, 5'b00000 | 5'b11000);
        idle("jmp_n3", 32'h308, 5'b00000);

        // Stall inside the flush window holds pc
        cyc(0, 0, 1, 1, 0, 0, 32'h400, "fst_n1", 32'h400, 5'b11100);
        cyc(0, 1, 0, 0, 0, 0, 32'h0, "fst_n2", 32'h400, 5'b11000);
        idle("fst_n3", 32'h404, 5'b00000);

        // Target bit 0 cleared, then pc wraps
        cyc(0, 0, 1, 0, 1, 0, 32'hFFFF_FFFD, "wrap_n1", 32'hFFFF_FFFC, 5'b11100);
        idle("wrap_n2", 32'h0, 5'b11000);
        idle("wrap_n3", 32'h4, 5'b00000);

        // Misaligned target halts; everything afterwards ignored
        cyc(0, 0, 1, 1, 0, 0, 32'h102, "mis", 32'h4, 5'b00011);
        cyc(0, 0, 1, 1, 0, 0, 32'h100, "mis_req", 32'h4, 5'b00011);
        idle("mis_hold", 32'h4, 5'b00011);
        cyc(1, 0, 0, 0, 0, 0, 32'h0, "mis_rst", 32'h0, 5'b00000);

        // ECALL beats a concurrent taken branch
        cyc(0, 0, 1, 1, 0, 1, 32'h100, "ecall", 32'h0, 5'b00001);
        idle("ecall_hold", 32'h0, 5'b00001);
        cyc(1, 0, 0, 0, 0, 0, 32'h0, "final_rst", 32'h0, 5'b00000);

`ifdef BRANCH_STATS_EN
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 1, 0, 0, 32'h100, "st_br1", 32'h100, 5'b11100);
            idle("st_br2", 32'h104, 5'b11000);
            idle("st_br3", 32'h108, 5'b00000);
        end
        cyc(0, 0, 1, 1, 1, 0, 32'h200, "st_j1", 32'h200, 5'b11100);
        idle("st_j2", 32'h204, 5'b11000);
        idle("st_j3", 32'h208, 5'b00000);
        check_val("taken_cnt", taken_cnt, 32'd3);
        check_val("jump_cnt", jump_cnt, 32'd1);
        check_val("flush_cycles_cnt", flush_cycles_cnt, 32'd8);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Owns the fetch PC register and sequences control-flow redirects in the pipelined RV32I core.
- Consumes the resolved branch condition (Branch_con) and jump/target info from EX; updates the PC.
- Drives IF/ID and ID/EX flush for a fixed squash window, honours hazard-unit stalls, and halts on ECALL/EBREAK or a misaligned target.
- Sits between the branch unit / EX stage and the PC/fetch logic.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles the flush outputs stay asserted per redirect; legal range 1..7.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; hold PC.
- ex_valid  in  1  EX holds a live (non-squashed) instruction.
- branch_con  in  1  branch taken, from branch unit.
- ex_jump  in  1  JAL/JALR in EX.
- ex_halt  in  1  ECALL/EBREAK in EX.
- ex_target  in  XLEN  computed branch/jump target.
- pc  out  XLEN  current fetch PC (registered).
- if_id_flush  out  1  squash IF/ID (registered).
- id_ex_flush  out  1  squash ID/EX (registered).
- redirect  out  1  one-cycle pulse: PC was loaded from a target this cycle.
- misaligned  out  1  sticky: target with bit[1]=1 was taken.
- halted  out  1  sticky: core halted.

Behaviour:
- One clock; reset is synchronous and active-high: clk, rst. All state updates on the posedge of clk.
- Reset values: pc=RESET_PC, flush outputs=0, redirect=0, misaligned=0, halted=0, state=RUN, flush counter=0.
- rst overrides everything, including mid-flush and HALT. An aborted flush window is discarded.
- Redirect request (req) = ex_valid & (branch_con | ex_jump).
- Effective target = {ex_target[XLEN-1:1], 1'b0}; bit 0 is always cleared.
- States: RUN, FLUSH, HALT.
- RUN, priority order (highest first):
  1. ex_valid & ex_halt: go to HALT. pc holds; halted=1 next cycle. Any concurrent req is ignored.
  2. req with ex_target[1]=1: go to HALT. misaligned=1 and halted=1 next cycle; pc holds.
  3. req: pc <= effective target. redirect=1 for that next cycle. Both flush outputs =1 from next cycle for exactly FLUSH_CYCLES cycles. Go to FLUSH if FLUSH_CYCLES>1, else stay in RUN.
  4. stall: pc holds.
  5. Otherwise: pc <= pc+4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- A redirect overrides a concurrent stall (the EX instruction is older). The stall is ignored that cycle.
- Latency: req sampled in cycle N -> new pc and flushes visible in cycle N+1.
- FLUSH:
  - Counter counts down to 0. Flushes stay asserted throughout.
  - req, ex_halt and ex_valid are ignored; EX contents are being squashed.
  - pc advances by +4 unless stall is high.
  - On the last flush cycle, return to RUN; flushes deassert the following cycle.
- HALT: pc frozen; flushes=0; redirect=0; all inputs ignored until rst.
- redirect is never high on two consecutive cycles.
- No output ever goes X after reset.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, add outputs:
  - taken_cnt (32 bits): counts accepted branch_con redirects.
  - jump_cnt (32 bits): counts accepted ex_jump redirects. A redirect with both branch_con and ex_jump counts as a jump only.
  - flush_cycles_cnt (32 bits): counts cycles with if_id_flush=1.
- Counters reset to 0 on rst, saturate at 32'hFFFF_FFFF, and freeze in HALT.
- When not defined, these ports and registers do not exist. Core behaviour is identical with or without the macro.

Test Plan:
1. Reset, then 3 free-running cycles -> pc = 0, 4, 8, 12; flushes=0, redirect=0, halted=0.
2. pc=0x10, stall=1 for 2 cycles -> pc holds 0x10 for both cycles, then resumes 0x14. Also rst=1 with pc=0x40 -> pc=0x0 next cycle.
3. ex_valid=1, branch_con=1, ex_target=0x100, stall=1 in cycle N -> cycle N+1: pc=0x100, redirect=1, both flushes=1. N+2: flushes=1, redirect=0, pc=0x104. N+3: flushes=0, pc=0x108.
4. Second req (target 0x200) during the FLUSH window -> ignored; pc follows 0x104, 0x108. Then ex_jump=1, target=0x301 -> pc=0x300.
5. req with ex_target=0x102 -> next cycle misaligned=1, halted=1, pc unchanged. Further reqs do nothing. rst clears everything to RESET_PC.
6. ex_halt=1 with branch_con=1 and ex_valid=1 -> halted=1, pc frozen, redirect=0.
   - With BRANCH_STATS_EN defined: 3 taken branches + 1 jump -> taken_cnt=3, jump_cnt=1, flush_cycles_cnt=8.
